// File: rtl/game_pos_writer_pkg.sv
// Shared definitions for the game-state writer: FSM encoding, position-word offsets
// (also used by the VGA sprite reader) and the 640x480 vblank start line.
package game_pos_writer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_UPDATE = 3'd1,
        ST_WR0    = 3'd2,
        ST_WR1    = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    localparam int unsigned POS_CACTUS_X_OFS  = 32'd0;
    localparam int unsigned POS_MAN_Y_OFS     = 32'd1;
    localparam logic [9:0]  VBLANK_START_LINE = 10'd480;

endpackage

// File: rtl/game_pos_writer_if.sv
// RAM write port (port A) carrying the position words into shared sprite RAM.
interface game_pos_writer_if #(
    parameter int ADDR_WIDTH = 16
) ();
    logic [ADDR_WIDTH-1:0] ram_addr_a;
    logic [15:0]           ram_data_a;
    logic                  ram_we_a;

    modport master (output ram_addr_a, output ram_data_a, output ram_we_a);
    modport slave  (input  ram_addr_a, input  ram_data_a, input  ram_we_a);
endinterface

// File: rtl/game_pos_writer_jump_physics.sv
// Combinational jump physics: optional jump start, integration, landing and top clamp.
module game_pos_writer_jump_physics #(
    parameter logic [9:0] GROUND_Y = 10'd300,
    parameter logic [7:0] JUMP_VEL = 8'd12,
    parameter logic [7:0] GRAVITY  = 8'd1
) (
    input  logic [9:0]        man_y_i,
    input  logic signed [8:0] vel_i,
    input  logic              airborne_i,
    input  logic              jump_pending_i,
    output logic [9:0]        man_y_o,
    output logic signed [8:0] vel_o,
    output logic              airborne_o
);
    logic signed [8:0]  vel_s;
    logic               air_s;
    logic signed [11:0] y_next_s;
    logic signed [8:0]  vel_next_s;

    // A jump starts before integration, so the first airborne frame already moves.
    always_comb begin
        vel_s      = vel_i;
        air_s      = airborne_i;
        if (!airborne_i && jump_pending_i) begin
            vel_s = -$signed({1'b0, JUMP_VEL});
            air_s = 1'b1;
        end else begin
            vel_s = vel_i;
        end
        y_next_s   = $signed({2'b00, man_y_i}) + {{3{vel_s[8]}}, vel_s};
        vel_next_s = vel_s + $signed({1'b0, GRAVITY});
        man_y_o    = man_y_i;
        vel_o      = vel_s;
        airborne_o = air_s;
        if (air_s) begin
            if (y_next_s >= $signed({2'b00, GROUND_Y})) begin
                man_y_o    = GROUND_Y;
                vel_o      = 9'sd0;
                airborne_o = 1'b0;
            end else if (y_next_s < 12'sd0) begin
                man_y_o = 10'd0;
                vel_o   = 9'sd0;
            end else begin
                man_y_o = y_next_s[9:0];
                vel_o   = vel_next_s;
            end
        end else begin
            man_y_o = man_y_i;
        end
    end
endmodule

// File: rtl/game_pos_writer.sv
// Per-frame game-state engine: scrolls the cactus, runs jump physics and writes both
// position words to sprite RAM. Define GAME_POS_JUMP_EDGE_EN for one jump per press.
module game_pos_writer
    import game_pos_writer_pkg::*;
#(
    parameter int                    ADDR_WIDTH     = 16,
    parameter logic [ADDR_WIDTH-1:0] POS_BASE       = 16'h8000,
    parameter logic [9:0]            WRITE_LINE     = 10'd482,
    parameter logic [9:0]            GROUND_Y       = 10'd300,
    parameter logic [7:0]            JUMP_VEL       = 8'd12,
    parameter logic [7:0]            GRAVITY        = 8'd1,
    parameter logic [9:0]            SCROLL_SPEED   = 10'd4,
    parameter logic [9:0]            CACTUS_START_X = 10'd639
) (
    input  logic                    pix_clk,
    input  logic                    reset,
    input  logic [9:0]              hcount_i,
    input  logic [9:0]              vcount_i,
    input  logic                    jump_btn_i,
    game_pos_writer_if.master       ram_if,
    output logic [9:0]              cactus_x_o,
    output logic [9:0]              man_y_o,
    output logic                    airborne_o,
    output logic                    frame_done_o
);
    state_e                  state_q, state_d;
    logic [9:0]              cactus_x_q, cactus_x_d;
    logic [9:0]              man_y_q, man_y_d;
    logic signed [8:0]       vel_q, vel_d;
    logic                    airborne_q, airborne_d;
    logic                    jump_pending_q, jump_pending_d;
    logic                    ram_we_q, ram_we_d;
    logic [ADDR_WIDTH-1:0]   ram_addr_q, ram_addr_d;
    logic [15:0]             ram_data_q, ram_data_d;
    logic                    frame_done_q, frame_done_d;
    logic                    trigger_s;
    logic                    jump_set_s;
    logic [9:0]              cactus_scroll_s;
    logic [9:0]              phys_y_s;
    logic signed [8:0]       phys_vel_s;
    logic                    phys_air_s;

    assign trigger_s = (hcount_i == 10'd0) && (vcount_i == WRITE_LINE);

`ifdef GAME_POS_JUMP_EDGE_EN
    logic [1:0] jump_sync_q;
    logic       jump_prev_q;

    // Synchronise the button and remember its last value for rising-edge detection.
    always_ff @(posedge pix_clk) begin
        if (reset) begin
            jump_sync_q <= 2'b00;
            jump_prev_q <= 1'b0;
        end else begin
            jump_sync_q <= {jump_sync_q[0], jump_btn_i};
            jump_prev_q <= jump_sync_q[1];
        end
    end

    assign jump_set_s = jump_sync_q[1] & ~jump_prev_q;
`else
    assign jump_set_s = jump_btn_i;
`endif

    game_pos_writer_jump_physics #(
        .GROUND_Y (GROUND_Y),
        .JUMP_VEL (JUMP_VEL),
        .GRAVITY  (GRAVITY)
    ) u_jump_physics (
        .man_y_i        (man_y_q),
        .vel_i          (vel_q),
        .airborne_i     (airborne_q),
        .jump_pending_i (jump_pending_q),
        .man_y_o        (phys_y_s),
        .vel_o          (phys_vel_s),
        .airborne_o     (phys_air_s)
    );

    // FSM state register.
    always_ff @(posedge pix_clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a trigger is only honoured in IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (trigger_s) begin
                    state_d = ST_UPDATE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_UPDATE: state_d = ST_WR0;
            ST_WR0:    state_d = ST_WR1;
            ST_WR1:    state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Game-state update and write-port values, decoded from the next state so the
    // registered port lines up with WR0/WR1.
    always_comb begin
        if (cactus_x_q < SCROLL_SPEED) begin
            cactus_scroll_s = CACTUS_START_X;
        end else begin
            cactus_scroll_s = cactus_x_q - SCROLL_SPEED;
        end
        cactus_x_d     = cactus_x_q;
        man_y_d        = man_y_q;
        vel_d          = vel_q;
        airborne_d     = airborne_q;
        jump_pending_d = jump_pending_q | jump_set_s;
        ram_we_d       = 1'b0;
        ram_addr_d     = ram_addr_q;
        ram_data_d     = ram_data_q;
        frame_done_d   = 1'b0;
        case (state_q)
            ST_UPDATE: begin
                cactus_x_d     = cactus_scroll_s;
                man_y_d        = phys_y_s;
                vel_d          = phys_vel_s;
                airborne_d     = phys_air_s;
                jump_pending_d = 1'b0;
            end
            default: begin
                cactus_x_d = cactus_x_q;
            end
        endcase
        case (state_d)
            ST_WR0: begin
                ram_we_d   = 1'b1;
                ram_addr_d = POS_BASE + ADDR_WIDTH'(POS_CACTUS_X_OFS);
                ram_data_d = {6'b000000, cactus_x_d};
            end
            ST_WR1: begin
                ram_we_d   = 1'b1;
                ram_addr_d = POS_BASE + ADDR_WIDTH'(POS_MAN_Y_OFS);
                ram_data_d = {6'b000000, man_y_d};
            end
            ST_DONE: begin
                frame_done_d = 1'b1;
            end
            default: begin
                ram_we_d = 1'b0;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge pix_clk) begin
        if (reset) begin
            cactus_x_q     <= CACTUS_START_X;
            man_y_q        <= GROUND_Y;
            vel_q          <= 9'sd0;
            airborne_q     <= 1'b0;
            jump_pending_q <= 1'b0;
            ram_we_q       <= 1'b0;
            ram_addr_q     <= '0;
            ram_data_q     <= 16'd0;
            frame_done_q   <= 1'b0;
        end else begin
            cactus_x_q     <= cactus_x_d;
            man_y_q        <= man_y_d;
            vel_q          <= vel_d;
            airborne_q     <= airborne_d;
            jump_pending_q <= jump_pending_d;
            ram_we_q       <= ram_we_d;
            ram_addr_q     <= ram_addr_d;
            ram_data_q     <= ram_data_d;
            frame_done_q   <= frame_done_d;
        end
    end

    assign ram_if.ram_we_a   = ram_we_q;
    assign ram_if.ram_addr_a = ram_addr_q;
    assign ram_if.ram_data_a = ram_data_q;
    assign cactus_x_o        = cactus_x_q;
    assign man_y_o           = man_y_q;
    assign airborne_o        = airborne_q;
    assign frame_done_o      = frame_done_q;
endmodule

// File: tb/tb_game_pos_writer.sv
// Scoreboard bench for game_pos_writer: a reference game model queues the expected
// RAM writes per frame and a negedge monitor pops and compares them.
module tb_game_pos_writer;

`ifdef GAME_POS_JUMP_EDGE_EN
    localparam bit EDGE_MODE = 1'b1;
`else
    localparam bit EDGE_MODE = 1'b0;
`endif
    localparam logic [15:0] BASE = 16'h8000;

    logic       pix_clk = 1'b0;
    logic       reset;
    logic [9:0] hcount, vcount;
    logic       jump_btn;
    logic [9:0] cactus_x, man_y;
    logic       airborne, frame_done;

    always #5 pix_clk = ~pix_clk;

    game_pos_writer_if #(.ADDR_WIDTH(16)) ram_if ();

    game_pos_writer dut (
        .pix_clk      (pix_clk),
        .reset        (reset),
        .hcount_i     (hcount),
        .vcount_i     (vcount),
        .jump_btn_i   (jump_btn),
        .ram_if       (ram_if),
        .cactus_x_o   (cactus_x),
        .man_y_o      (man_y),
        .airborne_o   (airborne),
        .frame_done_o (frame_done)
    );

    int n_cmp = 0;
    int n_err = 0;
    int n_writes = 0;
    int n_done = 0;
    logic [31:0] exp_q[$];

    int m_cx, m_y, m_vel;
    bit m_air, m_pend, btn_held;
    int trace[0:63];
    bit air_trace[0:63];

    task automatic check_val(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Monitor: every write must match the head of the scoreboard queue.
    always @(negedge pix_clk) begin
        if (ram_if.ram_we_a) begin
            n_writes++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_write: got addr %0h data %0d expected no write",
                         ram_if.ram_addr_a, ram_if.ram_data_a);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                check_val("wr_addr", ram_if.ram_addr_a, e[31:16]);
                check_val("wr_data", ram_if.ram_data_a, e[15:0]);
            end
        end
        if (frame_done) n_done++;
    end

    task automatic tick();
        @(posedge pix_clk);
        #1;
    endtask

    task automatic model_reset();
        m_cx = 639; m_y = 300; m_vel = 0; m_air = 1'b0; m_pend = 1'b0;
    endtask

    // Reference frame update; queues the two writes it implies.
    task automatic model_update();
        int yn;
        if (m_cx < 4) m_cx = 639;
        else m_cx = m_cx - 4;
        if (!m_air && m_pend) begin
            m_vel = -12;
            m_air = 1'b1;
        end
        if (m_air) begin
            yn = m_y + m_vel;
            if (yn >= 300) begin
                m_y = 300; m_vel = 0; m_air = 1'b0;
            end else if (yn < 0) begin
                m_y = 0; m_vel = 0;
            end else begin
                m_y = yn; m_vel = m_vel + 1;
            end
        end
        m_pend = 1'b0;
        if (btn_held && !EDGE_MODE) m_pend = 1'b1;
        exp_q.push_back({BASE, 6'd0, 10'(m_cx)});
        exp_q.push_back({BASE + 16'd1, 6'd0, 10'(m_y)});
    endtask

    task automatic run_frame(input bit dbl_trigger);
        model_update();
        hcount = 10'd0; vcount = 10'd482;
        tick();
        if (dbl_trigger) tick();
        hcount = 10'd1; vcount = 10'd100;
        repeat (11) tick();
    endtask

    task automatic press_pulse();
        jump_btn = 1'b1;
        tick();
        jump_btn = 1'b0;
        m_pend = 1'b1;
        repeat (4) tick();
    endtask

    initial begin
        int w0, d0;
        reset = 1'b1; hcount = 10'd1; vcount = 10'd0; jump_btn = 1'b0; btn_held = 1'b0;
        repeat (3) tick();
        check_val("rst_cactus_x", cactus_x, 639);
        check_val("rst_man_y", man_y, 300);
        check_val("rst_airborne", airborne, 0);
        check_val("rst_we", ram_if.ram_we_a, 0);
        check_val("rst_addr", ram_if.ram_addr_a, 0);
        check_val("rst_data", ram_if.ram_data_a, 0);
        check_val("rst_frame_done", frame_done, 0);
        reset = 1'b0;
        model_reset();
        tick();

        // Frame 1 with cycle-exact write timing.
        w0 = n_writes; d0 = n_done;
        model_update();
        hcount = 10'd0; vcount = 10'd482;
        tick();
        hcount = 10'd1; vcount = 10'd100;
        check_val("f1_update_we", ram_if.ram_we_a, 0);
        tick();
        check_val("f1_wr0_we", ram_if.ram_we_a, 1);
        check_val("f1_wr0_addr", ram_if.ram_addr_a, 16'h8000);
        check_val("f1_wr0_data", ram_if.ram_data_a, 635);
        tick();
        check_val("f1_wr1_we", ram_if.ram_we_a, 1);
        check_val("f1_wr1_addr", ram_if.ram_addr_a, 16'h8001);
        check_val("f1_wr1_data", ram_if.ram_data_a, 300);
        tick();
        check_val("f1_done_we", ram_if.ram_we_a, 0);
        check_val("f1_frame_done", frame_done, 1);
        tick();
        check_val("f1_frame_done_end", frame_done, 0);
        check_val("f1_addr_hold", ram_if.ram_addr_a, 16'h8001);
        repeat (6) tick();
        check_val("f1_write_count", n_writes - w0, 2);
        check_val("f1_done_count", n_done - d0, 1);

        // Frame 2 holds the trigger into UPDATE; the second one must be ignored.
        w0 = n_writes;
        run_frame(1'b1);
        check_val("dbl_trig_writes", n_writes - w0, 2);

        // Frames 3..160: scroll and wrap.
        for (int f = 3; f <= 160; f++) begin
            run_frame(1'b0);
            if (f == 159) check_val("cactus_f159", cactus_x, 3);
            if (f == 160) check_val("cactus_f160", cactus_x, 639);
        end
        check_val("man_y_no_jump", man_y, 300);

        // Single jump pulse.
        press_pulse();
        for (int k = 1; k <= 26; k++) begin
            run_frame(1'b0);
            trace[k] = man_y; air_trace[k] = airborne;
        end
        check_val("jump_f1", trace[1], 288);
        check_val("jump_f2", trace[2], 277);
        check_val("jump_f3", trace[3], 267);
        check_val("jump_peak_f12", trace[12], 222);
        check_val("jump_peak_f13", trace[13], 222);
        check_val("jump_air_f24", air_trace[24], 1);
        check_val("jump_land_f25", trace[25], 300);
        check_val("jump_air_f25", air_trace[25], 0);

        // Press while airborne at frame 5 is dropped.
        press_pulse();
        for (int k = 1; k <= 26; k++) begin
            if (k == 5) press_pulse();
            run_frame(1'b0);
            trace[k] = man_y; air_trace[k] = airborne;
        end
        check_val("air_press_land_f25", trace[25], 300);
        check_val("air_press_air_f25", air_trace[25], 0);
        check_val("air_press_cleared_f26", trace[26], 300);

        // Hold the button for 60 frames.
        jump_btn = 1'b1; btn_held = 1'b1; m_pend = 1'b1;
        repeat (4) tick();
        for (int k = 1; k <= 60; k++) begin
            run_frame(1'b0);
            trace[k] = man_y;
        end
        jump_btn = 1'b0; btn_held = 1'b0;
        check_val("hold_f1", trace[1], 288);
        check_val("hold_land_f25", trace[25], 300);
        check_val("hold_f26", trace[26], EDGE_MODE ? 300 : 288);
        repeat (4) tick();

        // Reset during WR0 aborts the frame before the man-Y write.
        model_update();
        void'(exp_q.pop_back());
        hcount = 10'd0; vcount = 10'd482;
        tick();
        hcount = 10'd1; vcount = 10'd100;
        tick();
        check_val("abort_in_wr0", ram_if.ram_we_a, 1);
        reset = 1'b1;
        tick();
        check_val("abort_we", ram_if.ram_we_a, 0);
        check_val("abort_addr", ram_if.ram_addr_a, 0);
        check_val("abort_data", ram_if.ram_data_a, 0);
        check_val("abort_cactus_x", cactus_x, 639);
        check_val("abort_man_y", man_y, 300);
        check_val("abort_airborne", airborne, 0);
        reset = 1'b0;
        model_reset();
        w0 = n_writes; d0 = n_done;
        repeat (10) tick();
        check_val("abort_no_more_writes", n_writes - w0, 0);
        check_val("abort_no_done", n_done - d0, 0);
        check_val("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
